// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the five-stage F/D/E/M/W pipeline.
// It detects hazards that the bypass network cannot cover and drives the
// per-stage stall, bubble and flush controls. It also sequences data-memory
// waits and fixed-latency mul/div occupancy, and it counts stall cycles.
// The first cycle of a memory wait or of a mul/div op stalls combinationally.
// The FSM only remembers what is still owed after that first cycle.
module hazard_ctrl #(
    parameter int MULDIV_LAT  = 4,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       hz_d_reg_raddr1_i,
    input  logic [4:0]       hz_d_reg_raddr2_i,
    input  logic             hz_d_use_rs1_i,
    input  logic             hz_d_use_rs2_i,
    input  logic             hz_d_branch_i,
    input  logic             hz_d_redirect_i,
    input  logic             hz_E_reg_wen_i,
    input  logic [4:0]       hz_E_reg_waddr_i,
    input  logic             hz_E_mem_read_i,
    input  logic             hz_E_muldiv_i,
    input  logic             hz_M_reg_wen_i,
    input  logic [4:0]       hz_M_reg_waddr_i,
    input  logic             hz_M_mem_read_i,
    input  logic             hz_M_mem_req_i,
    input  logic             hz_dmem_ready_i,
    output logic             hz_stall_F_o,
    output logic             hz_stall_D_o,
    output logic             hz_flush_D_o,
    output logic             hz_stall_E_o,
    output logic             hz_bubble_E_o,
    output logic             hz_stall_M_o,
    output logic             hz_bubble_M_o,
    output logic             hz_bubble_W_o,
    output logic             hz_mem_err_o,
    output logic [CNT_W-1:0] hz_stall_cnt_o
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam int MD_W   = $clog2(MULDIV_LAT);
    // The counter holds the E cycles still owed after the current one.
    // The op goes back to RUN when only its final, unstalled cycle remains.
    localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MULDIV_LAT - 1);
    localparam logic [MD_W-1:0] MD_LAST = MD_W'(2);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MULDIV   = 2'd2
    } state_t;

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [MD_W-1:0]   r_md_cnt;
    // Set when the access in M has completed or timed out. It stops the same
    // request from re-arming a wait while that instruction is still in M.
    logic              r_m_done;
    // Set when the mul/div in E has served its stall cycles. It stops the
    // op from re-triggering during its final cycle in E.
    logic              r_md_done;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic        w_match_e;
    logic        w_match_m;
    logic        w_data_haz;
    logic [31:0] w_wait_num;
    logic        w_mem_stall;
    logic        w_timeout;
    logic        w_mem_done;
    logic        w_md_start;
    logic        w_md_stall;
    logic        w_data_stall;
    logic        w_stall_fd;
    logic [8:0]  w_ctrl;

    // A source operand depends on a producer only for a real, used register.
    function automatic logic f_match(input logic [4:0] x, input logic use_x,
                                     input logic [4:0] rd, input logic wen);
        return use_x && wen && (x == rd) && (x != 5'd0);
    endfunction

    assign w_match_e = f_match(hz_d_reg_raddr1_i, hz_d_use_rs1_i, hz_E_reg_waddr_i, hz_E_reg_wen_i)
                     | f_match(hz_d_reg_raddr2_i, hz_d_use_rs2_i, hz_E_reg_waddr_i, hz_E_reg_wen_i);
    assign w_match_m = f_match(hz_d_reg_raddr1_i, hz_d_use_rs1_i, hz_M_reg_waddr_i, hz_M_reg_wen_i)
                     | f_match(hz_d_reg_raddr2_i, hz_d_use_rs2_i, hz_M_reg_waddr_i, hz_M_reg_wen_i);

    // Load-use and branch-in-D operand hazards. A load feeding a branch
    // stalls twice: once while the load is in E, once while it is in M.
    assign w_data_haz = (hz_E_mem_read_i & w_match_e)
                      | (hz_d_branch_i & w_match_e)
                      | (hz_d_branch_i & hz_M_mem_read_i & w_match_m);

    // Wait-cycle number of the current cycle, counting from 1.
    assign w_wait_num  = ((r_state == MEM_WAIT) ? 32'(r_wait_cnt) : 32'd0) + 32'd1;
    assign w_mem_stall = (r_state == MEM_WAIT)
                       | (hz_M_mem_req_i & ~r_m_done & ~hz_dmem_ready_i);
    assign w_timeout   = w_mem_stall & ~hz_dmem_ready_i & (w_wait_num == 32'(MEM_TIMEOUT));
    assign w_mem_done  = w_mem_stall & (hz_dmem_ready_i | w_timeout);

    assign w_md_start   = (r_state == RUN) & hz_E_muldiv_i & ~r_md_done;
    assign w_md_stall   = ~w_mem_stall & ((r_state == MULDIV) | w_md_start);
    assign w_data_stall = ~w_mem_stall & ~w_md_stall & (r_state == RUN) & w_data_haz;
    assign w_stall_fd   = w_mem_stall | w_md_stall | w_data_stall;

    // The three stall sources are mutually exclusive, so stall and bubble
    // never land on the same pipeline register.
    assign w_ctrl = {w_stall_fd,                          // stall_F
                     w_stall_fd,                          // stall_D
                     hz_d_redirect_i & ~w_stall_fd,       // flush_D
                     w_mem_stall | w_md_stall,            // stall_E
                     w_data_stall,                        // bubble_E
                     w_mem_stall,                         // stall_M
                     w_md_stall,                          // bubble_M
                     w_mem_stall,                         // bubble_W
                     w_timeout};                          // mem_err

    // Outputs are forced low while reset is held, even if pipeline inputs are still live.
    assign {hz_stall_F_o, hz_stall_D_o, hz_flush_D_o, hz_stall_E_o, hz_bubble_E_o,
            hz_stall_M_o, hz_bubble_M_o, hz_bubble_W_o, hz_mem_err_o} = w_ctrl & {9{rst_n}};
    assign hz_stall_cnt_o = r_stall_cnt;

    // Controller FSM: a memory wait preempts and freezes an in-flight mul/div.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_md_cnt   <= '0;
            r_m_done   <= 1'b0;
            r_md_done  <= 1'b0;
        end else if (w_mem_stall) begin
            if (w_mem_done) begin
                r_m_done   <= 1'b1;
                r_wait_cnt <= '0;
                r_state    <= (r_md_cnt != '0) ? MULDIV : RUN;
            end else begin
                r_state    <= MEM_WAIT;
                r_wait_cnt <= w_wait_num[WAIT_W-1:0];
            end
        end else begin
            r_m_done <= 1'b0;
            if (w_md_stall) begin
                if (r_state == MULDIV) begin
                    if (r_md_cnt == MD_LAST) begin
                        r_state   <= RUN;
                        r_md_cnt  <= '0;
                        r_md_done <= 1'b1;
                    end else begin
                        r_md_cnt <= r_md_cnt - 1'b1;
                    end
                end else if (MULDIV_LAT > 2) begin
                    r_state  <= MULDIV;
                    r_md_cnt <= MD_LOAD;
                end else begin
                    r_md_done <= 1'b1;
                end
            end else begin
                r_md_done <= 1'b0;
            end
        end
    end

    // Saturating count of cycles in which the PC is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall_fd && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule
